// File: rtl/pipeline_pkg.sv
// Shared types and constants for the program-load / debug-readback port.
package pipeline_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned REG_IDX_W = 5;

endpackage

// File: rtl/imem_1w1r.sv
// Instruction memory: one synchronous write port, one asynchronous read port, no reset.
module imem_1w1r #(
    parameter int unsigned Depth = 1024,
    parameter int unsigned Aw    = $clog2(Depth)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [Aw-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [Aw-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_load_dbg_port.sv
// Program-load / debug-readback responder: owns imem, gates the core, serves RF/DM readback.
// Optional run-cycle counter enabled by defining PROG_LOAD_CYCLE_CNT_EN.
module prog_load_dbg_port #(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned DMEM_AW    = 10,
    parameter logic [31:0] NOP_INSTR  = pipeline_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        address,
    input  logic [31:0]        instruction,
    input  logic               DataOrReg,
    input  logic [31:0]        check_address,
    output logic [31:0]        value,
    input  logic [31:0]        fetch_pc,
    output logic [31:0]        fetch_instr,
    output logic               core_run,
    output logic               core_clear,
    output logic [4:0]         rf_dbg_addr,
    input  logic [31:0]        rf_dbg_data,
    output logic [DMEM_AW-1:0] dm_dbg_addr,
    input  logic [31:0]        dm_dbg_data,
    output logic               load_err
);

    import pipeline_pkg::*;

    localparam int unsigned IAW = $clog2(IMEM_DEPTH);

    state_e       state_q, state_d;
    logic [IAW:0] prog_len_q, prog_len_d, prog_len_base;
    logic         load_err_q, load_err_d;
    logic         core_run_q, core_clear_q;
    logic [31:0]  value_q, value_d;

    logic           addr_ok, enter_load, imem_we, fetch_hit;
    logic [IAW:0]   addr_p1;
    logic [IAW-1:0] fetch_widx;
    logic [31:0]    imem_rdata;

    assign addr_ok    = (address < 32'(IMEM_DEPTH));
    assign enter_load = start && (state_q != StLoad);
    assign imem_we    = start && addr_ok;
    assign addr_p1    = {1'b0, address[IAW-1:0]} + (IAW + 1)'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start)  state_d = StLoad;
            StLoad:  if (!start) state_d = StRun;
            StRun:   if (start)  state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    // The edge that enters LOAD also performs that cycle's write, so clear and max-update combine.
    always_comb begin
        prog_len_base = enter_load ? '0 : prog_len_q;
        prog_len_d    = prog_len_base;
        load_err_d    = enter_load ? 1'b0 : load_err_q;
        if (start) begin
            if (addr_ok) begin
                if (addr_p1 > prog_len_base) prog_len_d = addr_p1;
            end else begin
                load_err_d = 1'b1;
            end
        end
    end

`ifdef PROG_LOAD_CYCLE_CNT_EN
    logic [31:0] run_cycles_q, run_cycles_d;
    logic        clear_next;

    assign clear_next = (state_q == StLoad) && (state_d == StRun);

    always_comb begin
        run_cycles_d = run_cycles_q;
        if (clear_next) begin
            run_cycles_d = '0;
        end else if (core_run_q && (run_cycles_q != 32'hFFFF_FFFF)) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_cycles_q <= '0;
        else        run_cycles_q <= run_cycles_d;
    end
`endif

    always_comb begin
        if (DataOrReg) begin
            value_d = dm_dbg_data;
        end else if (check_address[4:0] == '0) begin
            value_d = '0;
        end else begin
            value_d = rf_dbg_data;
        end
`ifdef PROG_LOAD_CYCLE_CNT_EN
        if (!DataOrReg && check_address[31]) value_d = run_cycles_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            prog_len_q   <= '0;
            load_err_q   <= 1'b0;
            core_run_q   <= 1'b0;
            core_clear_q <= 1'b0;
            value_q      <= '0;
        end else begin
            state_q      <= state_d;
            prog_len_q   <= prog_len_d;
            load_err_q   <= load_err_d;
            core_run_q   <= (state_d == StRun);
            core_clear_q <= (state_q == StLoad) && (state_d == StRun);
            value_q      <= value_d;
        end
    end

    imem_1w1r #(
        .Depth (IMEM_DEPTH),
        .Aw    (IAW)
    ) u_imem (
        .clk     (clk),
        .we_i    (imem_we),
        .waddr_i (address[IAW-1:0]),
        .wdata_i (instruction),
        .raddr_i (fetch_widx),
        .rdata_o (imem_rdata)
    );

    // Fetches outside the loaded program (or imem range) see a harmless NOP.
    assign fetch_widx  = fetch_pc[IAW+1:2];
    assign fetch_hit   = (fetch_pc[31:IAW+2] == '0) && ({1'b0, fetch_widx} < prog_len_q);
    assign fetch_instr = fetch_hit ? imem_rdata : NOP_INSTR;

    assign rf_dbg_addr = check_address[REG_IDX_W-1:0];
    assign dm_dbg_addr = check_address[DMEM_AW-1:0];
    assign value       = value_q;
    assign core_run    = core_run_q;
    assign core_clear  = core_clear_q;
    assign load_err    = load_err_q;

    logic unused_bits;
    assign unused_bits = ^{fetch_pc[1:0], check_address[31:DMEM_AW]};

endmodule

// File: tb/tb_prog_load_dbg_port.sv
// Bench for prog_load_dbg_port: directed table, hand sequences, and random run vs. a behavioural model.
module tb_prog_load_dbg_port;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] address, instruction, check_address, fetch_pc;
    logic        DataOrReg;
    logic [31:0] value, fetch_instr, rf_dbg_data, dm_dbg_data;
    logic        core_run, core_clear, load_err;
    logic [4:0]  rf_dbg_addr;
    logic [9:0]  dm_dbg_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_load_dbg_port dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .address       (address),
        .instruction   (instruction),
        .DataOrReg     (DataOrReg),
        .check_address (check_address),
        .value         (value),
        .fetch_pc      (fetch_pc),
        .fetch_instr   (fetch_instr),
        .core_run      (core_run),
        .core_clear    (core_clear),
        .rf_dbg_addr   (rf_dbg_addr),
        .rf_dbg_data   (rf_dbg_data),
        .dm_dbg_addr   (dm_dbg_addr),
        .dm_dbg_data   (dm_dbg_data),
        .load_err      (load_err)
    );

    // Behavioural model: what has been loaded, and what the core/readback should show.
    logic [31:0] m_mem [1024];
    int          m_len;
    bit          m_err, m_run, m_clear, m_loading;
    logic [31:0] m_value, m_cnt;

    task automatic model_reset();
        m_len = 0; m_err = 0; m_run = 0; m_clear = 0; m_loading = 0;
        m_value = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] m_fetch(input logic [31:0] pc);
        int w;
        if (pc[31:12] != 0) return NOP;
        w = int'(pc[11:2]);
        return (w < m_len) ? m_mem[w] : NOP;
    endfunction

    task automatic model_edge();
        bit old_run;
        if (DataOrReg) m_value = dm_dbg_data;
        else if (check_address[4:0] == 0) m_value = 0;
        else m_value = rf_dbg_data;
`ifdef PROG_LOAD_CYCLE_CNT_EN
        if (!DataOrReg && check_address[31]) m_value = m_cnt;
`endif
        old_run = m_run;
        if (start) begin
            if (!m_loading) begin m_len = 0; m_err = 0; end
            if (address < 32'd1024) begin
                m_mem[address[9:0]] = instruction;
                if (int'(address) + 1 > m_len) m_len = int'(address) + 1;
            end else begin
                m_err = 1;
            end
            m_run = 0; m_clear = 0;
        end else begin
            m_clear = m_loading;
            m_run   = m_loading || m_run;
        end
        if (m_clear) m_cnt = 0;
        else if (old_run && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_loading = start;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rnd_run", {31'b0, core_run}, {31'b0, m_run});
        chk("rnd_clear", {31'b0, core_clear}, {31'b0, m_clear});
        chk("rnd_err", {31'b0, load_err}, {31'b0, m_err});
        chk("rnd_value", value, m_value);
        chk("rnd_fetch", fetch_instr, m_fetch(fetch_pc));
        chk("rnd_rfaddr", {27'b0, rf_dbg_addr}, {27'b0, check_address[4:0]});
        chk("rnd_dmaddr", {22'b0, dm_dbg_addr}, {22'b0, check_address[9:0]});
    endtask

    typedef struct {
        logic        start;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] fpc;
        logic        run;
        logic        clr;
        logic [31:0] fetch;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 32'd0, 32'h0050_0093, 32'd8,      1'b0, 1'b0, NOP};
        tbl[1] = '{1'b1, 32'd1, 32'h0030_0113, 32'd0,      1'b0, 1'b0, 32'h0050_0093};
        tbl[2] = '{1'b1, 32'd2, 32'h0020_81B3, 32'd8,      1'b0, 1'b0, 32'h0020_81B3};
        tbl[3] = '{1'b1, 32'd3, 32'h0000_0013, 32'd16,     1'b0, 1'b0, NOP};
        tbl[4] = '{1'b0, 32'd0, 32'h0,         32'd8,      1'b1, 1'b1, 32'h0020_81B3};
        tbl[5] = '{1'b0, 32'd0, 32'h0,         32'd16,     1'b1, 1'b0, NOP};
        tbl[6] = '{1'b0, 32'd0, 32'h0,         32'h1000,   1'b1, 1'b0, NOP};
        tbl[7] = '{1'b0, 32'd0, 32'h0,         32'd4,      1'b1, 1'b0, 32'h0030_0113};

        rst_n = 1'b0; start = 0; address = 0; instruction = 0; DataOrReg = 0;
        check_address = 0; fetch_pc = 0; rf_dbg_data = 0; dm_dbg_data = 0;
        model_reset();
        #12 rst_n = 1'b1;
        #1;
        chk("reset_run", {31'b0, core_run}, 32'd0);
        chk("reset_clear", {31'b0, core_clear}, 32'd0);
        chk("reset_value", value, 32'd0);
        chk("reset_err", {31'b0, load_err}, 32'd0);
        chk("reset_fetch", fetch_instr, NOP);

        for (int i = 0; i < 8; i++) begin
            start = tbl[i].start; address = tbl[i].addr;
            instruction = tbl[i].instr; fetch_pc = tbl[i].fpc;
            tick();
            chk($sformatf("tbl%0d_run", i), {31'b0, core_run}, {31'b0, tbl[i].run});
            chk($sformatf("tbl%0d_clear", i), {31'b0, core_clear}, {31'b0, tbl[i].clr});
            chk($sformatf("tbl%0d_fetch", i), fetch_instr, tbl[i].fetch);
            chk($sformatf("tbl%0d_err", i), {31'b0, load_err}, 32'd0);
        end

        // Readback, one cycle latency.
        DataOrReg = 0; check_address = 3; rf_dbg_data = 32'hDEAD_BEEF;
        tick();
        chk("rb_rf3", value, 32'hDEAD_BEEF);
        check_address = 0;
        tick();
        chk("rb_rf0", value, 32'd0);
        DataOrReg = 1; dm_dbg_data = 32'h1;
        tick();
        chk("rb_dm", value, 32'd1);
        check_address = 32'hFFFF_F3C5;
        #1;
        chk("rb_rfaddr", {27'b0, rf_dbg_addr}, 32'd5);
        chk("rb_dmaddr", {22'b0, dm_dbg_addr}, 32'h3C5);
        check_address = 0;

        // Restart mid-RUN: old program length is forgotten.
        start = 1; address = 0; instruction = 32'h1111_1111; fetch_pc = 4;
        tick();
        chk("rst_run_drop", {31'b0, core_run}, 32'd0);
        chk("rst_len_cleared", fetch_instr, NOP);
        fetch_pc = 0; #1;
        chk("rst_new_word", fetch_instr, 32'h1111_1111);
        start = 0;
        tick();
        chk("rst_clear", {31'b0, core_clear}, 32'd1);
        chk("rst_run", {31'b0, core_run}, 32'd1);
        tick();
        chk("rst_clear_once", {31'b0, core_clear}, 32'd0);

        // Out-of-range load address.
        start = 1; address = 0; instruction = 32'hAAAA_0001;
        tick();
        address = 1024; instruction = 32'hBBBB_0002;
        tick();
        chk("oor_err", {31'b0, load_err}, 32'd1);
        chk("oor_nowrite", fetch_instr, 32'hAAAA_0001);
        start = 0;
        tick();
        chk("oor_err_run", {31'b0, load_err}, 32'd1);
        chk("oor_clear", {31'b0, core_clear}, 32'd1);
        tick(); tick();
        chk("oor_err_sticky", {31'b0, load_err}, 32'd1);
        start = 1; address = 5; instruction = 32'hCCCC_0003;
        tick();
        chk("oor_err_cleared", {31'b0, load_err}, 32'd0);
        start = 0;
        tick(); tick();

        // Asynchronous reset between edges while running.
        #3 rst_n = 0;
        #1;
        chk("arst_run", {31'b0, core_run}, 32'd0);
        chk("arst_value", value, 32'd0);
        fetch_pc = 0; #1;
        chk("arst_fetch0", fetch_instr, NOP);
        fetch_pc = 20; #1;
        chk("arst_fetch20", fetch_instr, NOP);
        model_reset();
        #1 rst_n = 1;

        // Random phase: fill all of imem so every fetch is fully predictable.
        for (int i = 0; i < 1024; i++) begin
            start = 1; address = i; instruction = $urandom;
            DataOrReg = 1'($urandom); check_address = $urandom;
            rf_dbg_data = $urandom; dm_dbg_data = $urandom;
            fetch_pc = $urandom_range(0, 4400);
            tick();
            compare_all();
        end
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) start = ~start;
            case ($urandom_range(0, 15))
                0:       address = 32'd1024 + $urandom_range(0, 100);
                1:       address = $urandom;
                default: address = $urandom_range(0, 1023);
            endcase
            instruction = $urandom;
            fetch_pc = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 4400);
            DataOrReg = 1'($urandom); check_address = $urandom;
            rf_dbg_data = $urandom; dm_dbg_data = $urandom;
            tick();
            compare_all();
        end

`ifdef PROG_LOAD_CYCLE_CNT_EN
        start = 1; address = 0; instruction = 32'h13; DataOrReg = 1;
        tick();
        start = 0;
        tick();
        repeat (10) tick();
        DataOrReg = 0; check_address = 32'h8000_0000;
        tick();
        chk("cnt_value", value, 32'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_load_dbg_port.md
Name: prog_load_dbg_port

Overview:
- Core-side responder for the program-load / debug-readback interface that the bench drives on `pipeline`.
- Owns the instruction memory. While `start`=1 it accepts one instruction word per cycle.
- Holds the core idle during load and releases it with a clean PC clear when `start` falls.
- Serves register-file or data-memory readback on `value` through `DataOrReg` / `check_address`.
- Instantiated inside `pipeline` between the top-level ports and the IF stage / debug read ports.

Parameters:
- IMEM_DEPTH, 1024, instruction words held; index width IAW = clog2(IMEM_DEPTH).
- DMEM_AW, 10, data-memory debug word-address width.
- NOP_INSTR, 32'h0000_0013, word returned for fetches at or beyond the loaded program length.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1 = load mode; falling edge launches execution.
- address  in  32  word index of the instruction being loaded.
- instruction  in  32  instruction word to load.
- DataOrReg  in  1  readback source: 1 = data memory, 0 = register file.
- check_address  in  32  readback index.
- value  out  32  registered readback data.
- fetch_pc  in  32  IF-stage byte PC.
- fetch_instr  out  32  instruction to IF stage (combinational).
- core_run  out  1  core may advance PC / pipeline.
- core_clear  out  1  one-cycle pulse: core zeroes PC and flushes pipeline.
- rf_dbg_addr  out  5  register-file debug read index (combinational).
- rf_dbg_data  in  32  register-file debug read data (combinational).
- dm_dbg_addr  out  DMEM_AW  data-memory debug word index (combinational).
- dm_dbg_data  in  32  data-memory debug read data (combinational).
- load_err  out  1  sticky: a load address was >= IMEM_DEPTH.

Behaviour:
- Clock, reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- Reset values: state=IDLE, core_run=0, core_clear=0, value=0, load_err=0, prog_len=0. The imem array is not reset.
- FSM (registered):
  - IDLE: start=1 -> LOAD.
  - LOAD: start=0 -> RUN.
  - RUN: start=1 -> LOAD.
- Entering LOAD from IDLE or RUN clears prog_len and load_err.
- LOAD, every cycle:
  - If address < IMEM_DEPTH: imem[address[IAW-1:0]] <= instruction, and prog_len <= max(prog_len, address+1).
  - Else: no write; load_err <= 1.
  - Writing the same index twice keeps the last word.
- The write cycle is the same edge that samples start=1. The cycle where start is sampled 0 performs no write.
- core_run = (state==RUN), registered, so it rises one cycle after start is sampled low.
- core_clear is high for exactly the first RUN cycle (LOAD->RUN transition) and is coincident with core_run's rise.
- RUN->LOAD: core_run drops on the next edge. In-flight instructions are discarded; the next RUN entry pulses core_clear.
- Fetch:
  - Word index widx = fetch_pc[IAW+1:2].
  - fetch_instr = imem[widx] if fetch_pc[31:IAW+2]==0 and widx < prog_len, else NOP_INSTR.
  - Same behaviour in every state.
  - Misaligned fetch_pc[1:0] is ignored.
- Readback, 1-cycle latency, any state:
  - value <= DataOrReg ? dm_dbg_data : (check_address[4:0]==0 ? 0 : rf_dbg_data).
  - rf_dbg_addr = check_address[4:0]; dm_dbg_addr = check_address[DMEM_AW-1:0]; upper bits ignored.
- Reset mid-LOAD or mid-RUN: returns to IDLE, prog_len=0. Every fetch then returns NOP until a new load.

Optional Feature:
- Macro: PROG_LOAD_CYCLE_CNT_EN.
- Defined:
  - 32-bit run_cycles counter, cleared on core_clear, increments each cycle core_run=1, saturates at 32'hFFFF_FFFF.
  - Register readback (DataOrReg=0) with check_address[31]=1 returns run_cycles instead of the register file.
- Undefined: no counter; check_address[31] is ignored.

Decomposition:
- Shared package `pipeline_pkg`: state encoding (IDLE/LOAD/RUN), NOP_INSTR, REG_IDX_W=5.
- One natural sub-module: `imem_1w1r`, the IMEM_DEPTH x 32 array with a synchronous write port and an asynchronous read port.
- The FSM, prog_len tracking and readback mux stay in the top.

Test Plan:
- Reset, then start=1 writing addr 0..3 = 0x00500093, 0x00300113, 0x002081B3, 0x00000013, then start=0:
  - core_run=0 throughout load.
  - core_clear and core_run rise together one cycle after start low.
  - fetch_pc=8 -> 0x002081B3.
- After that load, fetch_pc=16 (index 4 = prog_len) -> 0x00000013.
- fetch_pc=32'h0000_1000 -> 0x00000013.
- Load address 1024 (IMEM_DEPTH):
  - load_err=1; no memory index changes.
  - load_err stays 1 until the next LOAD entry.
- Readback with rf_dbg_data=0xDEADBEEF:
  - DataOrReg=0, check_address=3 -> value=0xDEADBEEF one cycle later.
  - check_address=0 -> value=0.
  - DataOrReg=1, dm_dbg_data=0x1 -> value=1 next cycle.
- rst_n pulsed low mid-RUN (async, between edges):
  - core_run=0 and value=0 immediately.
  - Any fetch returns NOP.
- start re-asserted mid-RUN: core_run falls next edge; prog_len=0; a new load of index 0 then a start fall produces core_clear again.
- With PROG_LOAD_CYCLE_CNT_EN defined: 10 RUN cycles, then DataOrReg=0 and check_address=32'h8000_0000 -> value=10.
